wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the Raisin64 core. It shares the single register-file write port among NUM_UNITS execution units using round-robin arbitration. It drives the write port through a one-cycle registered stage and, in the same cycle as each write, produces the matching pending-register-table free port, so a destination register is marked not-busy exactly when its value lands.

## Interface
Parameters:
- NUM_UNITS, 4: number of requesting execution units; legal range 2–8.
- DATA_W, 64: register data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  NUM_UNITS  per-unit writeback request; bit i belongs to unit i.
- wb_rn  in  6*NUM_UNITS  per-unit destination register; unit i uses bits [6i+5:6i].
- wb_data  in  DATA_W*NUM_UNITS  per-unit result; unit i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- wb_ready  out  NUM_UNITS  per-unit grant; combinational; at most one bit high.
- rf_stall  in  1  when high, no grant is issued; the write port is reserved for another user.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  6  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- free_rn  out  6  register number to clear in the pending register table (registered).

## Operation
- Handshake: a transfer on unit i occurs in a cycle where wb_valid[i] and wb_ready[i] are both 1.
  - Once a unit asserts wb_valid[i], it holds wb_valid[i], wb_rn and wb_data stable until that transfer.
  - Units must not retract a request.
- Grant logic (combinational):
  - If rf_stall=1, or no request is valid, wb_ready is 0.
  - Otherwise, exactly one requesting unit is granted: the first valid unit found scanning upward from rr_ptr, wrapping modulo NUM_UNITS.
  - wb_ready depends only on wb_valid, rr_ptr and rf_stall. It does not depend on wb_rn or wb_data.
- Round-robin pointer:
  - rr_ptr has width clog2(NUM_UNITS).
  - On a transfer from unit g, rr_ptr <= (g+1) mod NUM_UNITS.
  - Otherwise rr_ptr holds its value.
- Output stage, on a transfer from unit g:
  - rf_waddr <= wb_rn[g], rf_wdata <= wb_data[g], free_rn <= wb_rn[g].
  - rf_we <= 1 if wb_rn[g] != 0, else 0.
- Register r0:
  - A writeback to r0 still completes the handshake and advances rr_ptr.
  - No register-file write occurs.
  - free_rn is 0, which is harmless because the pending table never marks r0 busy.
- No transfer in a cycle: rf_we <= 0, free_rn <= 0. Clearing r0 in the table is a no-op, so the free port needs no enable. rf_waddr and rf_wdata hold their previous values.
- Reset (asynchronous, any time including mid-transfer):
  - rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, free_rn=0.
  - wb_ready is 0 while rst_n=0.
  - A grant in the cycle reset asserts is discarded; the unit must re-request.
- The block has no state machine beyond rr_ptr and the output registers. The block never buffers more than one result.

## Timing
- Grant latency: 0 cycles. wb_ready[i] rises in the same cycle wb_valid[i] is seen, if unit i wins and rf_stall=0.
- Write latency: 1 cycle. A transfer at edge N produces rf_we, rf_waddr, rf_wdata and free_rn valid during cycle N+1. They are sampled by the register file and pending table at edge N+1.
- Throughput: one writeback per cycle. Back-to-back transfers from different units are allowed. Back-to-back transfers from the same unit are allowed if it is the only requester.
- Starvation bound: a unit holding wb_valid is granted within NUM_UNITS non-stalled cycles.
- rf_stall takes effect in the same cycle: no transfer occurs while it is high. An output produced by a transfer in the preceding cycle still completes.
- The same register being freed here and set busy by issue in the same cycle is resolved by the pending table's ordering; this block does not special-case it.

## Test plan
- Single request: unit 2 valid, rn=5, data=0x1234 → wb_ready=0b0100 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, free_rn=5; following cycle rf_we=0, free_rn=0.
- All four units request from reset with rn=1,2,3,4 → grants to units 0,1,2,3 on four consecutive cycles; rf_waddr=1,2,3,4 on the following four cycles; never two ready bits high.
- Fairness: rr_ptr=3 (after a grant to unit 2), units 1 and 3 valid → unit 3 granted first, then unit 1.
- r0 writeback: unit 0 valid, rn=0, data=0xFFFF → handshake completes, rr_ptr advances to 1; next cycle rf_we=0, free_rn=0.
- Stall: units 0 and 1 valid, rf_stall=1 for 3 cycles → wb_ready=0 and rf_we=0 throughout; on the release cycle unit 0 is granted.
- Reset mid-stream: assert rst_n=0 while unit 1 is being granted → all outputs 0 immediately, rr_ptr=0; after release, unit 1 (still valid) is granted and written exactly once.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter for the Raisin64 core.
// NUM_UNITS execution units share one register-file write port. The winning
// result is registered for one cycle and drives the register-file write port
// together with the pending-register-table free port, so a destination is
// marked not-busy in the same cycle its value is written.
module wb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        wb_valid,
    input  logic [6*NUM_UNITS-1:0]      wb_rn,
    input  logic [DATA_W*NUM_UNITS-1:0] wb_data,
    output logic [NUM_UNITS-1:0]        wb_ready,
    input  logic                        rf_stall,
    output logic                        rf_we,
    output logic [5:0]                  rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [5:0]                  free_rn
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    // Unit that gets first look at the write port in the next arbitration.
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Registered write-port / free-port stage.
    logic              rf_we_q, rf_we_d;
    logic [5:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [5:0]        free_rn_q, free_rn_d;

    // One-hot grant; doubles as the transfer strobe because a grant bit is
    // only ever raised for a unit whose request is valid.
    logic [NUM_UNITS-1:0] grant;
    logic [PTR_W-1:0]     scan_idx;
    logic                 found;

    // Scan upward from rr_ptr (wrapping) and grant the first valid unit.
    // Grants are suppressed during reset so a request seen while rst_n is low
    // is never acknowledged.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        grant    = '0;
        scan_idx = '0;
        found    = 1'b0;
        if (rst_n && !rf_stall) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
                if (!found && wb_valid[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
    end

    assign wb_ready = grant;

    // Next-state for the pointer and output stage: capture the winner, or
    // idle the write enable and free port while address/data hold.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        free_rn_d  = 6'd0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                rr_ptr_d   = PTR_W'((i + 1) % NUM_UNITS);
                rf_waddr_d = wb_rn[6*i +: 6];
                rf_wdata_d = wb_data[DATA_W*i +: DATA_W];
                free_rn_d  = wb_rn[6*i +: 6];
                // r0 is hardwired: the handshake completes but nothing is written.
                rf_we_d    = (wb_rn[6*i +: 6] != 6'd0);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 6'd0;
            rf_wdata_q <= '0;
            free_rn_q  <= 6'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its _d value from before this clock edge.
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            free_rn_q  <= free_rn_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign free_rn  = free_rn_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed testbench for wb_arbiter (NUM_UNITS=4, DATA_W=64).
// The stimulus process checks grants in the request cycle and queues the
// expected register-file write; a separate monitor pops the queue whenever the
// DUT presents a write and checks the idle state of the free port otherwise.
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    wb_valid;
    logic [6*N-1:0]  wb_rn;
    logic [DW*N-1:0] wb_data;
    logic [N-1:0]    wb_ready;
    logic            rf_stall;
    logic            rf_we;
    logic [5:0]      rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [5:0]      free_rn;

    wb_arbiter #(.NUM_UNITS(N), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_rn    (wb_rn),
        .wb_data  (wb_data),
        .wb_ready (wb_ready),
        .rf_stall (rf_stall),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .free_rn  (free_rn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    rn;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side view of each unit's request.
    logic [N-1:0]  pend;
    logic [5:0]    rn_v   [N];
    logic [DW-1:0] data_v [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        wb_valid = pend;
        for (int i = 0; i < N; i++) begin
            wb_rn[6*i +: 6]    = rn_v[i];
            wb_data[DW*i +: DW] = data_v[i];
        end
    endtask

    // One arbitration cycle, entered and left at a falling edge.
    task automatic step(input logic [N-1:0] exp_ready, input string name);
        exp_t e;
        drive();
        #1;
        check(name, 64'(wb_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i] && rn_v[i] != 6'd0) begin
                e.rn   = rn_v[i];
                e.data = data_v[i];
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        pend = pend & ~exp_ready;
        @(negedge clk);
    endtask

    // Monitor: every registered write must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rf_waddr), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rf_waddr", 64'(rf_waddr), 64'(e.rn));
                check("rf_wdata", rf_wdata, e.data);
                check("free_rn", 64'(free_rn), 64'(e.rn));
            end
        end else begin
            check("idle_free_rn", 64'(free_rn), 64'd0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        rf_stall = 1'b0;
        pend     = 4'b1111;
        for (int i = 0; i < N; i++) begin
            rn_v[i]   = 6'(i + 1);
            data_v[i] = 64'(i);
        end
        drive();

        // Reset state: no grant even with all units requesting.
        #2;
        check("reset_ready", 64'(wb_ready), 64'd0);
        check("reset_we", 64'(rf_we), 64'd0);
        check("reset_waddr", 64'(rf_waddr), 64'd0);
        check("reset_wdata", rf_wdata, 64'd0);
        check("reset_free", 64'(free_rn), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four units request from reset: grants 0,1,2,3 in order.
        rn_v   = '{6'd1, 6'd2, 6'd3, 6'd4};
        data_v = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        pend   = 4'b1111;
        step(4'b0001, "all4_g0");
        step(4'b0010, "all4_g1");
        step(4'b0100, "all4_g2");
        step(4'b1000, "all4_g3");

        // Single request from unit 2.
        rn_v[2]   = 6'd5;
        data_v[2] = 64'h1234;
        pend      = 4'b0100;
        step(4'b0100, "single_u2");
        step(4'b0000, "single_idle1");
        check("single_we_cleared", 64'(rf_we), 64'd0);
        check("single_free_cleared", 64'(free_rn), 64'd0);

        // Fairness: pointer at 3, units 1 and 3 request -> 3 then 1.
        rn_v[1] = 6'd11; data_v[1] = 64'hB1;
        rn_v[3] = 6'd13; data_v[3] = 64'hB3;
        pend    = 4'b1010;
        step(4'b1000, "fair_u3_first");
        step(4'b0010, "fair_u1_second");

        // Stall for three cycles with units 0 and 1 requesting (pointer at 2).
        rn_v[0] = 6'd20; data_v[0] = 64'hC0;
        rn_v[1] = 6'd21; data_v[1] = 64'hC1;
        pend     = 4'b0011;
        rf_stall = 1'b1;
        step(4'b0000, "stall_c1");
        step(4'b0000, "stall_c2");
        check("stall_we", 64'(rf_we), 64'd0);
        step(4'b0000, "stall_c3");
        check("stall_we_c3", 64'(rf_we), 64'd0);
        rf_stall = 1'b0;
        step(4'b0001, "stall_release_u0");
        step(4'b0010, "stall_then_u1");

        // r0 writeback from unit 0 (pointer at 2): no write, pointer moves to 1.
        rn_v[0] = 6'd0; data_v[0] = 64'hFFFF;
        pend    = 4'b0001;
        step(4'b0001, "r0_grant");
        check("r0_we", 64'(rf_we), 64'd0);
        check("r0_free", 64'(free_rn), 64'd0);
        // Pointer at 1: units 0 and 2 -> 2 wins first.
        rn_v[0] = 6'd7; data_v[0] = 64'hD0;
        rn_v[2] = 6'd8; data_v[2] = 64'hD2;
        pend    = 4'b0101;
        step(4'b0100, "r0_ptr_u2");
        step(4'b0001, "r0_ptr_u0");

        // Reset mid-stream: put pointer at 3 via a unit 2 grant, then reset
        // while unit 1 is being granted.
        rn_v[2] = 6'd30; data_v[2] = 64'hE2;
        pend    = 4'b0100;
        step(4'b0100, "pre_reset_u2");
        rn_v[1] = 6'd9; data_v[1] = 64'h99;
        pend    = 4'b0010;
        drive();
        #1;
        check("mid_grant_u1", 64'(wb_ready), 64'b0010);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(wb_ready), 64'd0);
        check("mid_rst_we", 64'(rf_we), 64'd0);
        check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        check("mid_rst_wdata", rf_wdata, 64'd0);
        check("mid_rst_free", 64'(free_rn), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Pointer must be 0 again: unit 1 beats unit 3.
        rn_v[3] = 6'd10; data_v[3] = 64'hAA;
        pend    = 4'b1010;
        step(4'b0010, "post_rst_u1");
        step(4'b1000, "post_rst_u3");
        step(4'b0000, "drain1");
        step(4'b0000, "drain2");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
